// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-ROM access arbiter.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_F = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   // addi x0,x0,0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // Misaligned, or word index past the end of the ROM. The full 30-bit index is compared, so
   // high addresses never alias onto low words.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/imem_rr_arb2.sv
// Two-way picker: round-robin on ties, or fixed F-first when fixed_i is set.
// Bit 0 is the fetch requester, bit 1 the debug requester.
module imem_rr_arb2
   import imem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  req_id_t    last_i,
   input  logic       fixed_i,
   output logic [1:0] gnt_o
);

   // On a tie, favour the requester that did not win last time unless priority is fixed.
   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11: begin
            if (fixed_i || (last_i == REQ_D)) gnt_o = 2'b01;
            else                              gnt_o = 2'b10;
         end
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/imem_access_arbiter.sv
// Shares the instruction ROM read port between CPU fetch (F) and debug (D).
// One access takes three cycles: grant in IDLE, ROM read in ACCESS, response pulse in RESP.
module imem_access_arbiter
   import imem_arb_pkg::*;
#(
   parameter int unsigned Depth     = 51,
   parameter bit          FixedPrio = 1'b0,
   parameter logic [31:0] NopWord   = NOP_WORD
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        f_req_i,
   input  logic [31:0] f_addr_i,
   output logic        f_gnt_o,
   output logic        f_rvalid_o,
   output logic        f_err_o,
   input  logic        d_req_i,
   input  logic [31:0] d_addr_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic        d_err_o,
   output logic [31:0] rdata_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   arb_state_t  state_q;
   req_id_t     winner_q;
   req_id_t     last_q;
   logic [31:0] addr_q;
   logic        err_pend_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] mem_addr_q;

   logic [1:0]  pick;
   logic [1:0]  grant;
   logic [31:0] req_addr;
   logic        resp_f;
   logic        resp_d;

   imem_rr_arb2 u_arb (
      .req_i   ({d_req_i, f_req_i}),
      .last_i  (last_q),
      .fixed_i (FixedPrio),
      .gnt_o   (pick)
   );

   // Grants are only issued from IDLE; the winner's address is the one latched.
   always_comb begin
      grant    = (state_q == IDLE) ? pick : 2'b00;
      req_addr = grant[1] ? d_addr_i : f_addr_i;
   end

   // Single FSM register block: latches the winner, performs the ROM read, emits the response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         winner_q   <= REQ_F;
         last_q     <= REQ_D;
         addr_q     <= 32'h0;
         err_pend_q <= 1'b0;
         rdata_q    <= 32'h0;
         err_q      <= 1'b0;
         mem_addr_q <= 32'h0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant != 2'b00) begin
                  winner_q   <= grant[1] ? REQ_D : REQ_F;
                  last_q     <= grant[1] ? REQ_D : REQ_F;
                  addr_q     <= req_addr;
                  err_pend_q <= addr_err(req_addr, Depth);
                  state_q    <= ACCESS;
               end
            end
            ACCESS: begin
               if (err_pend_q) begin
                  rdata_q <= NopWord;
                  err_q   <= 1'b1;
               end else begin
                  rdata_q    <= mem_rdata_i;
                  err_q      <= 1'b0;
                  mem_addr_q <= addr_q;
               end
               state_q <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Output decode; an erroring access leaves the ROM address where it was.
   always_comb begin
      resp_f     = (state_q == RESP) && (winner_q == REQ_F);
      resp_d     = (state_q == RESP) && (winner_q == REQ_D);
      f_gnt_o    = grant[0];
      d_gnt_o    = grant[1];
      f_rvalid_o = resp_f;
      d_rvalid_o = resp_d;
      f_err_o    = resp_f & err_q;
      d_err_o    = resp_d & err_q;
      rdata_o    = rdata_q;
      busy_o     = (state_q != IDLE);
      mem_addr_o = ((state_q == ACCESS) && !err_pend_q) ? addr_q : mem_addr_q;
   end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter: a round-robin instance and a fixed-priority instance.
module tb_imem_access_arbiter;

   logic clk;
   logic rst_n;

   logic        f_req, d_req;
   logic [31:0] f_addr, d_addr;
   logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, busy;
   logic [31:0] rdata, mem_addr, mem_rdata;

   logic        f_req1, d_req1;
   logic [31:0] f_addr1, d_addr1;
   logic        f_gnt1, f_rvalid1, f_err1, d_gnt1, d_rvalid1, d_err1, busy1;
   logic [31:0] rdata1, mem_addr1, mem_rdata1;

   int checks   = 0;
   int failures = 0;

   localparam int unsigned DEPTH = 51;
   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [31:0] rom(input logic [31:0] a);
      logic [29:0] idx;
      idx = a[31:2];
      case (idx)
         30'd0:   return 32'h0011_01B3;
         30'd1:   return 32'h4011_0233;
         30'd2:   return 32'h0121_12B3;
         default: return 32'hA500_0000 ^ {2'b00, idx};
      endcase
   endfunction

   assign mem_rdata  = rom(mem_addr);
   assign mem_rdata1 = rom(mem_addr1);

   imem_access_arbiter #(.Depth(DEPTH), .FixedPrio(1'b0), .NopWord(NOP)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid),
      .f_err_o(f_err),
      .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
      .d_err_o(d_err),
      .rdata_o(rdata), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   imem_access_arbiter #(.Depth(DEPTH), .FixedPrio(1'b1), .NopWord(NOP)) dut_fixed (
      .clk_i(clk), .rst_ni(rst_n),
      .f_req_i(f_req1), .f_addr_i(f_addr1), .f_gnt_o(f_gnt1), .f_rvalid_o(f_rvalid1),
      .f_err_o(f_err1),
      .d_req_i(d_req1), .d_addr_i(d_addr1), .d_gnt_o(d_gnt1), .d_rvalid_o(d_rvalid1),
      .d_err_o(d_err1),
      .rdata_o(rdata1), .mem_addr_o(mem_addr1), .mem_rdata_i(mem_rdata1), .busy_o(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in an IDLE cycle with requests already driven; ends in the following IDLE cycle.
   task automatic access(input string tag, input logic ef, input logic ed,
                         input logic [31:0] emem, input logic [31:0] erd, input logic eerr);
      chk({tag, ".f_gnt"}, {31'b0, f_gnt}, {31'b0, ef});
      chk({tag, ".d_gnt"}, {31'b0, d_gnt}, {31'b0, ed});
      chk({tag, ".busy_idle"}, {31'b0, busy}, 32'd0);
      step();
      chk({tag, ".busy_access"}, {31'b0, busy}, 32'd1);
      chk({tag, ".mem_addr"}, mem_addr, emem);
      chk({tag, ".gnt_access"}, {30'b0, f_gnt, d_gnt}, 32'd0);
      chk({tag, ".rvalid_access"}, {30'b0, f_rvalid, d_rvalid}, 32'd0);
      step();
      chk({tag, ".f_rvalid"}, {31'b0, f_rvalid}, {31'b0, ef});
      chk({tag, ".d_rvalid"}, {31'b0, d_rvalid}, {31'b0, ed});
      chk({tag, ".f_err"}, {31'b0, f_err}, {31'b0, ef & eerr});
      chk({tag, ".d_err"}, {31'b0, d_err}, {31'b0, ed & eerr});
      chk({tag, ".rdata"}, rdata, erd);
      chk({tag, ".gnt_resp"}, {30'b0, f_gnt, d_gnt}, 32'd0);
      step();
      chk({tag, ".rvalid_after"}, {30'b0, f_rvalid, d_rvalid}, 32'd0);
      chk({tag, ".busy_after"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      f_req   = 1'b0; d_req  = 1'b0; f_addr  = 32'h0; d_addr  = 32'h0;
      f_req1  = 1'b0; d_req1 = 1'b0; f_addr1 = 32'h0; d_addr1 = 32'h0;

      // Reset state
      #12;
      chk("rst.busy", {31'b0, busy}, 32'd0);
      chk("rst.rdata", rdata, 32'h0);
      chk("rst.mem_addr", mem_addr, 32'h0);
      chk("rst.rvalid_err", {28'b0, f_rvalid, d_rvalid, f_err, d_err}, 32'd0);
      rst_n = 1'b1;
      step();

      // Single fetch at address 0
      f_req = 1'b1; f_addr = 32'h0; #1;
      access("t1_f0", 1'b1, 1'b0, 32'h0, 32'h0011_01B3, 1'b0);

      // Lone debug access, leaving D as last winner
      f_req = 1'b0; d_req = 1'b1; d_addr = 32'h8; #1;
      access("t2_d_only", 1'b0, 1'b1, 32'h8, 32'h0121_12B3, 1'b0);

      // Both held: round-robin alternates F, D, F
      f_req = 1'b1; f_addr = 32'h4; #1;
      access("t2_rr_f1", 1'b1, 1'b0, 32'h4, 32'h4011_0233, 1'b0);
      access("t2_rr_d",  1'b0, 1'b1, 32'h8, 32'h0121_12B3, 1'b0);
      access("t2_rr_f2", 1'b1, 1'b0, 32'h4, 32'h4011_0233, 1'b0);

      // Errors: misaligned, one past the end, highest valid word, high-bit alias
      f_req = 1'b0; d_addr = 32'h2; #1;
      access("t3_misalign", 1'b0, 1'b1, 32'h4, NOP, 1'b1);
      d_addr = 32'd204; #1;
      access("t3_past_end", 1'b0, 1'b1, 32'h4, NOP, 1'b1);
      d_addr = 32'd200; #1;
      access("t3_last_word", 1'b0, 1'b1, 32'd200, 32'hA500_0032, 1'b0);
      d_addr = 32'h8000_0000; #1;
      access("t3_alias", 1'b0, 1'b1, 32'd200, NOP, 1'b1);

      // Reset during ACCESS of an F grant: no response, and F wins the next tie
      d_req = 1'b0; f_req = 1'b1; f_addr = 32'h0; #1;
      chk("t5.f_gnt", {31'b0, f_gnt}, 32'd1);
      step();
      f_req = 1'b0;
      chk("t5.busy_access", {31'b0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5.busy_rst", {31'b0, busy}, 32'd0);
      chk("t5.rdata_rst", rdata, 32'h0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5.no_rvalid", {30'b0, f_rvalid, d_rvalid}, 32'd0);
         chk("t5.idle", {31'b0, busy}, 32'd0);
      end
      f_req = 1'b1; d_req = 1'b1; f_addr = 32'h4; d_addr = 32'h8; #1;
      access("t5_first_after", 1'b1, 1'b0, 32'h4, 32'h4011_0233, 1'b0);
      f_req = 1'b0; d_req = 1'b0;

      // Fixed priority: F keeps winning while both are held
      f_req1 = 1'b1; d_req1 = 1'b1; f_addr1 = 32'h4; d_addr1 = 32'h8; #1;
      for (int i = 0; i < 4; i++) begin
         chk("t4.f_gnt", {31'b0, f_gnt1}, 32'd1);
         chk("t4.d_gnt", {31'b0, d_gnt1}, 32'd0);
         step();
         chk("t4.d_gnt_access", {31'b0, d_gnt1}, 32'd0);
         step();
         chk("t4.f_rvalid", {31'b0, f_rvalid1}, 32'd1);
         chk("t4.d_rvalid", {31'b0, d_rvalid1}, 32'd0);
         chk("t4.rdata", rdata1, 32'h4011_0233);
         step();
      end
      f_req1 = 1'b0; d_req1 = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
